// File: rtl/mc_ctrl_if.sv
// Control-unit bundle between the multicycle MIPS controller and its datapath.
// The controller drives the master side; the datapath drives the instruction fields and the zero flag.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic       iord;
  logic       mem_we;
  logic       ir_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_we;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] pc_src;
  logic [3:0] state_o;

  modport master (
    input  op, funct, zero,
    output pc_en, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we,
           alu_src_a, alu_src_b, alu_ctrl, pc_src, state_o
  );

  modport slave (
    output op, funct, zero,
    input  pc_en, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we,
           alu_src_a, alu_src_b, alu_ctrl, pc_src, state_o
  );
endinterface

// File: rtl/mc_ctrl_unit.sv
// Multicycle MIPS main control FSM: Moore outputs per state.
// In BRANCH, pc_en follows the ALU zero flag.
module mc_ctrl_unit (
  input  logic        clk,
  input  logic        rst,
  mc_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q, state_d;
  logic       pc_en, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic       funct_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // R-type funct decode; an unknown funct falls back to add and skips writeback.
  always_comb begin
    funct_ok = 1'b1;
    case (bus.funct)
      6'b100000: alu_ctrl = ALU_ADD;
      6'b100010: alu_ctrl = ALU_SUB;
      6'b100100: alu_ctrl = ALU_AND;
      6'b100101: alu_ctrl = ALU_OR;
      6'b101010: alu_ctrl = ALU_SLT;
      default: begin
        alu_ctrl = ALU_ADD;
        funct_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        ir_we     = 1'b1;
        alu_src_b = 2'b01;
        pc_en     = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_we     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord    = 1'b1;
        mem_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = funct_ok ? S_ALUWB : S_FETCH;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = 2'b01;
        pc_en     = bus.zero;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.pc_en      = pc_en;
  assign bus.iord       = iord;
  assign bus.mem_we     = mem_we;
  assign bus.ir_we      = ir_we;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_we     = reg_we;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  // Only EXEC and BRANCH override the add code used by every other ALU-using state.
  assign bus.alu_ctrl   = (state_q == S_EXEC)   ? alu_ctrl :
                          (state_q == S_BRANCH) ? ALU_SUB :
                          (state_q == S_FETCH || state_q == S_DECODE ||
                           state_q == S_MEMADR || state_q == S_ADDIEX) ? ALU_ADD : 3'b000;
  assign bus.pc_src     = pc_src;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Bench for mc_ctrl_unit: directed and random instructions against a per-instruction step-list model.
// Also covers asynchronous reset in the middle of a store.
module tb_mc_ctrl_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mc_ctrl_if bus ();

  mc_ctrl_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] v;
  } step_t;

  step_t q[$];

  // {pc_en, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we, alu_src_a, alu_src_b, alu_ctrl, pc_src}
  function automatic logic [14:0] mk(logic pe, logic io, logic mw, logic iw, logic rd,
                                     logic m2r, logic rw, logic sa, logic [1:0] sb,
                                     logic [2:0] alu, logic [1:0] ps);
    return {pe, io, mw, iw, rd, m2r, rw, sa, sb, alu, ps};
  endfunction

  function automatic logic [14:0] observed();
    return {bus.pc_en, bus.iord, bus.mem_we, bus.ir_we, bus.reg_dst, bus.mem_to_reg,
            bus.reg_we, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.pc_src};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, starting at its FETCH.
  task automatic build(input logic [5:0] op, input logic [5:0] funct, input logic z);
    logic [2:0] alu;
    logic       known;
    q.delete();
    q.push_back('{st: 4'd1, v: mk(1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00)});
    q.push_back('{st: 4'd2, v: mk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00)});
    case (op)
      6'b100011: begin
        q.push_back('{st: 4'd3, v: mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00)});
        q.push_back('{st: 4'd4, v: mk(0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00)});
        q.push_back('{st: 4'd5, v: mk(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00)});
      end
      6'b101011: begin
        q.push_back('{st: 4'd3, v: mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00)});
        q.push_back('{st: 4'd6, v: mk(0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00)});
      end
      6'b000000: begin
        known = 1'b1;
        case (funct)
          6'b100000: alu = 3'b010;
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default: begin alu = 3'b010; known = 1'b0; end
        endcase
        q.push_back('{st: 4'd7, v: mk(0,0,0,0,0,0,0,1,2'b00,alu,2'b00)});
        if (known)
          q.push_back('{st: 4'd8, v: mk(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00)});
      end
      6'b000100:
        q.push_back('{st: 4'd9, v: mk(z,0,0,0,0,0,0,1,2'b00,3'b110,2'b01)});
      6'b001000: begin
        q.push_back('{st: 4'd10, v: mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00)});
        q.push_back('{st: 4'd11, v: mk(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00)});
      end
      6'b000010:
        q.push_back('{st: 4'd12, v: mk(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b10)});
      default: ;
    endcase
  endtask

  // Called while the DUT sits in FETCH (1 ns after the edge); returns in the next FETCH.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] funct,
                           input logic z);
    bus.op    = op;
    bus.funct = funct;
    bus.zero  = z;
    build(op, funct, z);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      #1;
      chk($sformatf("%s_st%0d", name, i), 32'(bus.state_o), 32'(q[i].st));
      chk($sformatf("%s_out%0d", name, i), 32'(observed()), 32'(q[i].v));
      chk($sformatf("%s_we_excl%0d", name, i), 32'(bus.mem_we & bus.reg_we), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ops [8]    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                             6'b001000, 6'b000010, 6'b111111, 6'b010101};
  logic [5:0] functs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                             6'b101010, 6'b000111};

  initial begin
    bus.op    = 6'd0;
    bus.funct = 6'd0;
    bus.zero  = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(bus.state_o), 32'd0);
    chk("reset_outs", 32'(observed()), 32'd0);
    rst = 1'b0;
    #2;
    chk("idle_state", 32'(bus.state_o), 32'd0);
    chk("idle_outs", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;

    run_instr("lw",       6'b100011, 6'b000000, 1'b0);
    run_instr("sw",       6'b101011, 6'b000000, 1'b1);
    run_instr("r_slt",    6'b000000, 6'b101010, 1'b0);
    run_instr("r_sub",    6'b000000, 6'b100010, 1'b1);
    run_instr("r_badfn",  6'b000000, 6'b111111, 1'b0);
    run_instr("beq_t",    6'b000100, 6'b000000, 1'b1);
    run_instr("beq_nt",   6'b000100, 6'b000000, 1'b0);
    run_instr("badop",    6'b111111, 6'b100000, 1'b1);
    run_instr("j",        6'b000010, 6'b000000, 1'b0);
    run_instr("addi",     6'b001000, 6'b000000, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] rop, rfn;
      rop = (n % 5 == 4) ? 6'($urandom) : ops[$urandom_range(7, 0)];
      rfn = functs[$urandom_range(5, 0)];
      run_instr($sformatf("rnd%0d", n), rop, rfn, 1'($urandom));
    end

    // Store interrupted by reset: reach MEMWR, then pull rst between edges.
    bus.op = 6'b101011;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_state", 32'(bus.state_o), 32'd6);
    chk("pre_rst_memwe", 32'(bus.mem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(bus.state_o), 32'd0);
    chk("async_rst_memwe", 32'(bus.mem_we), 32'd0);
    chk("async_rst_outs", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    chk("held_rst_state", 32'(bus.state_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_idle", 32'(bus.state_o), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_fetch", 32'(bus.state_o), 32'd1);
    chk("post_rst_fetch_outs", 32'(observed()), 32'(mk(1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
